// File: rtl/inst_buffer.sv
// -----------------------------------------------------------------------------
// inst_buffer
//   Decoupling FIFO between fetch and decode. It accepts up to FETCH_WIDTH
//   instructions per cycle from fetch and compacts them into a circular array.
//   It presents the oldest two entries, in program order, to the decoders.
//   It absorbs decode/rename backpressure and discards its contents on flush.
//
// Ports
//   clk          in   core clock, all state updates on the rising edge
//   rst_n        in   asynchronous active-low reset
//   flush        in   redirect/mispredict; empties the buffer (highest priority)
//   fetch_valid  in   fetch bundle offered this cycle
//   fetch_mask   in   per-slot valid of the bundle (never 00 while fetch_valid)
//   fetch_pc     in   slot PCs, slot 0 is older
//   fetch_inst   in   slot instruction words
//   fetch_ready  out  bundle accepted when fetch_valid & fetch_ready
//   dec_valid    out  output slot valid; [1] implies [0]
//   dec_pc       out  PC of head / head+1
//   dec_inst     out  instruction of head / head+1
//   dec_pop      in   decode consumes slot(s): 00, 01 or 11
//
// Optional feature (macro INST_BUF_STATS_EN)
//   Adds stat_full_cycles and stat_empty_cycles, two saturating 32-bit
//   counters that are cleared by reset only, not by flush.
// -----------------------------------------------------------------------------
module inst_buffer #(
    parameter int DEPTH       = 4,
    parameter int FETCH_WIDTH = 2,
    parameter int ADDR_BITS   = 32,
    parameter int INST_BITS   = 32
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  flush,
    input  logic                                  fetch_valid,
    input  logic [FETCH_WIDTH-1:0]                fetch_mask,
    input  logic [FETCH_WIDTH-1:0][ADDR_BITS-1:0] fetch_pc,
    input  logic [FETCH_WIDTH-1:0][INST_BITS-1:0] fetch_inst,
    output logic                                  fetch_ready,
    output logic [FETCH_WIDTH-1:0]                dec_valid,
    output logic [FETCH_WIDTH-1:0][ADDR_BITS-1:0] dec_pc,
    output logic [FETCH_WIDTH-1:0][INST_BITS-1:0] dec_inst,
    input  logic [FETCH_WIDTH-1:0]                dec_pop
`ifdef INST_BUF_STATS_EN
    ,
    output logic [31:0]                           stat_full_cycles,
    output logic [31:0]                           stat_empty_cycles
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Entry payloads are never reset; dec_valid qualifies them.
    logic [ADDR_BITS-1:0] r_pc_mem   [DEPTH];
    logic [INST_BITS-1:0] r_inst_mem [DEPTH];

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             w_accept;
    logic [1:0]       w_enq_cnt;
    logic [1:0]       w_deq_cnt;
    logic [PTR_W-1:0] w_wr_ptr1;

    // Readiness depends on the registered count only. A pop in the same
    // cycle does not give credit, so the check stays off the decode path.
    assign fetch_ready = (r_count <= CNT_W'(DEPTH - FETCH_WIDTH));
    assign w_accept    = fetch_valid & fetch_ready & ~flush;
    assign w_enq_cnt   = w_accept ? ({1'b0, fetch_mask[0]} + {1'b0, fetch_mask[1]}) : 2'd0;
    assign w_deq_cnt   = {1'b0, dec_pop[0]} + {1'b0, dec_pop[1]};

    // Compaction: slot 1 lands at the tail when slot 0 is absent,
    // and at the tail plus one otherwise.
    assign w_wr_ptr1   = r_tail + PTR_W'(fetch_mask[0]);

    always_ff @(posedge clk) begin
        if (w_accept) begin
            if (fetch_mask[0]) begin
                r_pc_mem[r_tail]   <= fetch_pc[0];
                r_inst_mem[r_tail] <= fetch_inst[0];
            end
            if (fetch_mask[1]) begin
                r_pc_mem[w_wr_ptr1]   <= fetch_pc[1];
                r_inst_mem[w_wr_ptr1] <= fetch_inst[1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_deq_cnt);
            r_tail  <= r_tail + PTR_W'(w_enq_cnt);
            r_count <= r_count + CNT_W'(w_enq_cnt) - CNT_W'(w_deq_cnt);
        end
    end

    // Output slot gi shows entry head+gi. There is no bypass from the
    // enqueue port, so a new bundle becomes visible one cycle later.
    genvar gi;
    generate
        for (gi = 0; gi < FETCH_WIDTH; gi++) begin : g_slot
            logic [PTR_W-1:0] w_rd_ptr;
            assign w_rd_ptr      = r_head + PTR_W'(gi);
            assign dec_valid[gi] = (r_count > CNT_W'(gi));
            assign dec_pc[gi]    = r_pc_mem[w_rd_ptr];
            assign dec_inst[gi]  = r_inst_mem[w_rd_ptr];
        end
    endgenerate

`ifdef INST_BUF_STATS_EN
    logic [31:0] r_full_cycles;
    logic [31:0] r_empty_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full_cycles  <= '0;
            r_empty_cycles <= '0;
        end else begin
            if (fetch_valid && !fetch_ready && (r_full_cycles != '1)) begin
                r_full_cycles <= r_full_cycles + 32'd1;
            end
            if ((r_count == '0) && !flush && (r_empty_cycles != '1)) begin
                r_empty_cycles <= r_empty_cycles + 32'd1;
            end
        end
    end

    assign stat_full_cycles  = r_full_cycles;
    assign stat_empty_cycles = r_empty_cycles;
`endif

    // Protocol checks on the neighbouring stages.
    a_pop_legal : assert property (@(posedge clk) disable iff (!rst_n)
        (dec_pop != 2'b10) && ((dec_pop & ~dec_valid) == '0));
    a_mask_legal : assert property (@(posedge clk) disable iff (!rst_n)
        fetch_valid |-> (fetch_mask != '0));

endmodule

// File: tb/tb_inst_buffer.sv
// -----------------------------------------------------------------------------
// tb_inst_buffer
//   Self-checking bench for inst_buffer. Directed stimulus pushes each
//   accepted instruction into an expected queue. A monitor on the falling
//   edge compares dec_valid, fetch_ready and the presented slots against that
//   queue. It retires entries as decode pops them. Each test step also has
//   hand-computed point checks.
// -----------------------------------------------------------------------------
module tb_inst_buffer;

    localparam logic [31:0] KEY = 32'h5A00_0013;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush;
    logic             fetch_valid;
    logic [1:0]       fetch_mask;
    logic [1:0][31:0] fetch_pc;
    logic [1:0][31:0] fetch_inst;
    logic             fetch_ready;
    logic [1:0]       dec_valid;
    logic [1:0][31:0] dec_pc;
    logic [1:0][31:0] dec_inst;
    logic [1:0]       dec_pop;
`ifdef INST_BUF_STATS_EN
    logic [31:0]      stat_full_cycles;
    logic [31:0]      stat_empty_cycles;
`endif

    inst_buffer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .fetch_valid (fetch_valid),
        .fetch_mask  (fetch_mask),
        .fetch_pc    (fetch_pc),
        .fetch_inst  (fetch_inst),
        .fetch_ready (fetch_ready),
        .dec_valid   (dec_valid),
        .dec_pc      (dec_pc),
        .dec_inst    (dec_inst),
        .dec_pop     (dec_pop)
`ifdef INST_BUF_STATS_EN
        ,
        .stat_full_cycles  (stat_full_cycles),
        .stat_empty_cycles (stat_empty_cycles)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [31:0] pc0,
                         input logic [31:0] pc1, input logic [1:0] pop, input logic fl);
        fetch_valid   = v;
        fetch_mask    = m;
        fetch_pc[0]   = pc0;
        fetch_pc[1]   = pc1;
        fetch_inst[0] = pc0 ^ KEY;
        fetch_inst[1] = pc1 ^ KEY;
        dec_pop       = pop;
        flush         = fl;
    endtask

    // Advance one clock. acc tells whether this bundle is expected to be
    // accepted, which is decided by hand for every step.
    task automatic step(input bit acc);
        ent_t e;
        @(posedge clk);
        #1;
        if (flush) begin
            exp_q.delete();
        end else if (acc) begin
            for (int k = 0; k < 2; k++) begin
                if (fetch_mask[k]) begin
                    e.pc   = fetch_pc[k];
                    e.inst = fetch_pc[k] ^ KEY;
                    exp_q.push_back(e);
                end
            end
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
    endtask

    // Monitor: every falling edge, check the presented state and retire pops.
    int n_mon;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            n_mon = exp_q.size();
            chk("mon_dec_valid", 64'(dec_valid), 64'({n_mon >= 2, n_mon >= 1}));
            chk("mon_fetch_ready", 64'(fetch_ready), 64'(n_mon <= 2));
            for (int k = 0; k < 2; k++) begin
                if (k < n_mon && dec_valid[k]) begin
                    chk($sformatf("mon_pc%0d", k), 64'(dec_pc[k]), 64'(exp_q[k].pc));
                    chk($sformatf("mon_inst%0d", k), 64'(dec_inst[k]), 64'(exp_q[k].inst));
                end
            end
            if (dec_pop[0] && n_mon >= 1) void'(exp_q.pop_front());
            if (dec_pop[1] && n_mon >= 2) void'(exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dec_valid", 64'(dec_valid), 64'h0);
        chk("rst_fetch_ready", 64'(fetch_ready), 64'h1);
        rst_n = 1'b1;
        step(1'b0);

        // 1: one full bundle is visible one cycle later
        drive(1'b1, 2'b11, 32'h100, 32'h104, 2'b00, 1'b0);
        chk("t1_no_bypass", 64'(dec_valid), 64'h0);
        step(1'b1);
        chk("t1_dec_valid", 64'(dec_valid), 64'h3);
        chk("t1_pc0", 64'(dec_pc[0]), 64'h100);
        chk("t1_pc1", 64'(dec_pc[1]), 64'h104);
        drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
        step(1'b0);

        // 2: compaction of a mask=10 bundle, then a partial pop
        drive(1'b1, 2'b10, 32'hDEAD, 32'h208, 2'b00, 1'b0);
        step(1'b1);
        drive(1'b1, 2'b11, 32'h20C, 32'h210, 2'b00, 1'b0);
        step(1'b1);
        chk("t2_pc0", 64'(dec_pc[0]), 64'h208);
        chk("t2_pc1", 64'(dec_pc[1]), 64'h20C);
        drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b01, 1'b0);
        step(1'b0);
        chk("t2_pop_pc0", 64'(dec_pc[0]), 64'h20C);
        chk("t2_pop_pc1", 64'(dec_pc[1]), 64'h210);
        drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
        step(1'b0);

        // 3: fill, hold against backpressure, then drain
        drive(1'b1, 2'b11, 32'h300, 32'h304, 2'b00, 1'b0);
        step(1'b1);
        drive(1'b1, 2'b11, 32'h308, 32'h30C, 2'b00, 1'b0);
        step(1'b1);
        chk("t3_full_ready", 64'(fetch_ready), 64'h0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 2'b11, 32'h900, 32'h904, 2'b00, 1'b0);
            step(1'b0);
        end
        chk("t3_hold_ready", 64'(fetch_ready), 64'h0);
        chk("t3_hold_pc0", 64'(dec_pc[0]), 64'h300);
        drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
        step(1'b0);
        chk("t3_ready_after_pop", 64'(fetch_ready), 64'h1);
        chk("t3_pc0_after_pop", 64'(dec_pc[0]), 64'h308);
        drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
        step(1'b0);

        // 4: steady state at count=2 across many pointer wraps
        drive(1'b1, 2'b11, 32'h500, 32'h504, 2'b00, 1'b0);
        step(1'b1);
        pc = 32'h508;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 2'b11, pc, pc + 32'h4, 2'b11, 1'b0);
            step(1'b1);
            chk("t4_pc0", 64'(dec_pc[0]), 64'(pc));
            chk("t4_valid", 64'(dec_valid), 64'h3);
            pc = pc + 32'h8;
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
        step(1'b0);

        // 5: flush wins over a concurrent enqueue and pop at count=3
        drive(1'b1, 2'b11, 32'h600, 32'h604, 2'b00, 1'b0);
        step(1'b1);
        drive(1'b1, 2'b01, 32'h608, 32'h0, 2'b00, 1'b0);
        step(1'b1);
        chk("t5_count3_valid", 64'(dec_valid), 64'h3);
        drive(1'b1, 2'b11, 32'h700, 32'h704, 2'b01, 1'b1);
        step(1'b0);
        chk("t5_flush_valid", 64'(dec_valid), 64'h0);
        chk("t5_flush_ready", 64'(fetch_ready), 64'h1);
        drive(1'b1, 2'b01, 32'h400, 32'h0, 2'b00, 1'b0);
        step(1'b1);
        chk("t5_post_valid", 64'(dec_valid), 64'h1);
        chk("t5_post_pc0", 64'(dec_pc[0]), 64'h400);
        drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b01, 1'b0);
        step(1'b0);

        // 6: asynchronous reset mid-cycle, then statistics from a clean start
        drive(1'b1, 2'b11, 32'h800, 32'h804, 2'b00, 1'b0);
        step(1'b1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_async_valid", 64'(dec_valid), 64'h0);
        chk("t6_async_ready", 64'(fetch_ready), 64'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 2'b11, 32'h880, 32'h884, 2'b00, 1'b0);
        step(1'b1);
        drive(1'b1, 2'b11, 32'h888, 32'h88C, 2'b00, 1'b0);
        step(1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'b11, 32'hA00, 32'hA04, 2'b00, 1'b0);
            step(1'b0);
        end
`ifdef INST_BUF_STATS_EN
        chk("t6_stat_full", 64'(stat_full_cycles), 64'd5);
        chk("t6_stat_empty", 64'(stat_empty_cycles), 64'd1);
`endif
        chk("t6_pc0", 64'(dec_pc[0]), 64'h880);
        drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
        step(1'b0);
        drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
        step(1'b0);
        chk("t6_drained", 64'(dec_valid), 64'h0);
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
